// File: rtl/pedestrian_signal_controller.sv
// Pedestrian crossing controller fed by TrafficLightModule lamps; debounced button, WALK/FLASH timing, sticky fault.
// Latency: all outputs registered; walk rises the cycle after a red-phase start, fault the cycle after a bad sample.
// Backpressure: none; a request is held in ped_wait until the next red-phase start grants it.
module pedestrian_signal_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WALK_CYCLES     = 8,
    parameter int FLASH_CYCLES    = 6,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             ped_button,
    output logic             walk,
    output logic             dont_walk,
    output logic             ped_wait,
    output logic [CNT_W-1:0] countdown,
    output logic             fault
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_MAX     = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ONE     = DB_W'(1);
    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WAIT  = 3'd1;
    localparam logic [2:0] WALK  = 3'd2;
    localparam logic [2:0] FLASH = 3'd3;
    localparam logic [2:0] CLEAR = 3'd4;
    localparam logic [2:0] FAULT = 3'd5;

    logic [2:0]      state;
    logic            sync1;
    logic            sync2;
    logic [DB_W-1:0] db_cnt;
    logic            red_prev;
    logic            press;
    logic            red_start;
    logic            multi_hot;
    logic            bad_red;
    logic            fault_det;
    logic            accept_press;

    always_comb begin
        // Fires only on the sample that brings the count to DEBOUNCE_CYCLES; saturation blocks re-trigger.
        press        = sync2 && (db_cnt == DB_LAST);
        red_start    = red && !red_prev;
        multi_hot    = (red && yellow) || (red && green) || (yellow && green);
        bad_red      = !red && ((state == WALK) || (state == FLASH));
        fault_det    = multi_hot || bad_red;
        accept_press = press && ((state == IDLE) || (state == WAIT) || (state == CLEAR));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync1 <= ped_button;
            sync2 <= sync1;
            if (!sync2) begin
                db_cnt <= '0;
            end else if (db_cnt != DB_MAX) begin
                db_cnt <= db_cnt + DB_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            ped_wait  <= 1'b0;
            countdown <= CNT_ZERO;
            fault     <= 1'b0;
            red_prev  <= 1'b0;
        end else begin
            red_prev <= red;
            if (fault_det || (state == FAULT)) begin
                state     <= FAULT;
                fault     <= 1'b1;
                walk      <= 1'b0;
                dont_walk <= 1'b1;
                countdown <= CNT_ZERO;
                ped_wait  <= 1'b0;
            end else begin
                // Latch first so a grant in the same edge overrides it.
                if (accept_press) begin
                    ped_wait <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        walk      <= 1'b0;
                        dont_walk <= 1'b1;
                        countdown <= CNT_ZERO;
                        if (ped_wait) begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (red_start) begin
                            state     <= WALK;
                            ped_wait  <= 1'b0;
                            walk      <= 1'b1;
                            dont_walk <= 1'b0;
                            countdown <= WALK_LOAD;
                        end else begin
                            walk      <= 1'b0;
                            dont_walk <= 1'b1;
                            countdown <= CNT_ZERO;
                        end
                    end
                    WALK: begin
                        if (countdown == CNT_ZERO) begin
                            state     <= FLASH;
                            walk      <= 1'b0;
                            dont_walk <= 1'b1;
                            countdown <= FLASH_LOAD;
                        end else begin
                            countdown <= countdown - CNT_ONE;
                        end
                    end
                    FLASH: begin
                        if (countdown == CNT_ZERO) begin
                            state     <= CLEAR;
                            dont_walk <= 1'b1;
                        end else begin
                            dont_walk <= !dont_walk;
                            countdown <= countdown - CNT_ONE;
                        end
                    end
                    CLEAR: begin
                        walk      <= 1'b0;
                        dont_walk <= 1'b1;
                        countdown <= CNT_ZERO;
                        if (!red) begin
                            state <= ped_wait ? WAIT : IDLE;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        walk      <= 1'b0;
                        dont_walk <= 1'b1;
                        countdown <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/pedestrian_signal_controller.md
# pedestrian_signal_controller

Pedestrian crossing controller sitting directly downstream of `TrafficLightModule`. It consumes that module's `red`/`yellow`/`green` outputs and a raw pedestrian push-button. It grants a timed WALK interval only at the start of a red phase, followed by a flashing DON'T-WALK clearance interval. It also flags unsafe light combinations as a sticky fault.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive synchronized-high samples required to register a press.
- `WALK_CYCLES`, 8: cycles `walk` is held high per grant; must be ≥1.
- `FLASH_CYCLES`, 6: cycles of flashing `dont_walk` after WALK; must be ≥1.
- `CNT_W`, 8: width of `countdown`; must hold max(WALK_CYCLES, FLASH_CYCLES)−1.
- `clk`, input, 1: single clock, rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `red`, input, 1: from TrafficLightModule.
- `yellow`, input, 1: from TrafficLightModule.
- `green`, input, 1: from TrafficLightModule.
- `ped_button`, input, 1: raw, asynchronous push-button.
- `walk`, output, 1: WALK lamp.
- `dont_walk`, output, 1: DON'T-WALK lamp; flashes during clearance.
- `ped_wait`, output, 1: request latched, awaiting service.
- `countdown`, output, CNT_W: remaining cycles in WALK/FLASH; 0 otherwise.
- `fault`, output, 1: sticky safety fault.

## Operation
- **Reset** (`reset_n`=0 sampled at an edge):
  - state IDLE; `walk`=0, `dont_walk`=1, `ped_wait`=0, `countdown`=0, `fault`=0.
  - synchronizer and debounce counter cleared; `red_prev`=0.
- **Button path**:
  - 2-FF synchronizer feeds a debounce counter.
  - The counter increments on each synchronized-high sample and clears on any low sample.
  - A press registers once, on the edge where the count reaches `DEBOUNCE_CYCLES`.
  - No re-trigger until the synchronized button returns low.
- **Request latch**:
  - A registered press sets `ped_wait` in IDLE, WAIT and CLEAR.
  - Presses are ignored in WALK, FLASH and FAULT.
- **Red-phase start**: `red_start` = `red` sampled 1 this edge AND `red_prev`=0, where `red_prev` is the previous sample.
- **States**:
  - IDLE: `dont_walk`=1. Go to WAIT when `ped_wait` is set.
  - WAIT: `dont_walk`=1. On `red_start`, go to WALK, clear `ped_wait`, load `countdown`=WALK_CYCLES−1. A red phase already in progress does not grant; wait for the next rising edge of `red`.
  - WALK: `walk`=1, `dont_walk`=0. `countdown` decrements each edge. When it is 0, go to FLASH and load FLASH_CYCLES−1.
  - FLASH: `walk`=0. `dont_walk`=1 on the first FLASH cycle, then toggles every cycle. `countdown` decrements. When it is 0, go to CLEAR.
  - CLEAR: `dont_walk`=1, `countdown`=0. When `red` is sampled 0, go to WAIT if `ped_wait`=1, otherwise IDLE.
  - FAULT: `walk`=0, `dont_walk`=1, `countdown`=0, `ped_wait`=0. Exit only by reset.
- **Fault conditions** (checked every edge, in every state):
  - More than one of `red`/`yellow`/`green` sampled high.
  - `red` sampled 0 while in WALK or FLASH.
  - All three low is legal and is treated as "not red".
- **Priority**: reset > fault > state transition > request latch.

## Timing
- All outputs are registered.
- Inputs `red`/`yellow`/`green` are sampled directly; they are already synchronous to `clk` from the upstream module.
- **Button latency**: with the first edge sampling `ped_button`=1 counted as edge 1, `ped_wait`=1 after edge 2+DEBOUNCE_CYCLES (edge 6 at default).
- **Grant latency**: `walk`=1 in the cycle after the edge where `red_start` is detected.
- **Interval lengths**: `walk` is high exactly WALK_CYCLES cycles. FLASH lasts exactly FLASH_CYCLES cycles.
- **Press on the red_start edge** (request in IDLE): `ped_wait` sets, but the grant waits for the next red phase, because IDLE→WAIT takes one edge.
- **Fault latency**: `fault`=1, `walk`=0 and `dont_walk`=1 in the cycle after the offending sample.
- **Reset mid-WALK**: outputs return to reset values after the reset edge, with no FLASH interval.

## Test plan
- **Reset**: hold `reset_n`=0 for 3 edges with `green`=1 → `walk`=0, `dont_walk`=1, `ped_wait`=0, `countdown`=0, `fault`=0.
- **Debounce**:
  - `ped_button` high for 3 edges, then low → `ped_wait` stays 0.
  - High for 10 edges → `ped_wait`=1 after edge 6 and stays 1; exactly one request.
- **Full crossing**:
  - Stimulus: press, then lights green→yellow→red with red held ≥20 cycles.
  - Cycle after `red_start`: `walk`=1 for 8 cycles with `countdown` 7..0; `ped_wait` clears.
  - Then `dont_walk` = 1,0,1,0,1,0 with `countdown` 5..0.
  - Then `dont_walk`=1 steady; IDLE after `red` drops.
- **No request**: red phase with no press → `walk` never asserts, `dont_walk`=1 throughout.
- **Red drops during WALK**: press granted, `red` forced 0 in WALK cycle 3 → next cycle `walk`=0, `dont_walk`=1, `fault`=1. Later presses and red phases are ignored until reset.
- **Illegal lights and ignored press**:
  - `red`=`green`=1 for one cycle in IDLE → `fault`=1, sticky.
  - Separate run: press during WALK → `ped_wait` stays 0 after the grant completes.
